// File: rtl/ppwm_pkg.sv
// Shared types and helpers for the PWM controller slice.
package ppwm_pkg;

    // Sequencer states; any other encoding falls back to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StStop = 2'b10
    } ctrl_state_e;

    // Width of a channel-select field; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ppwm_if.sv
// Config write port plus the instruction-memory write bus it drives.
// The host side is the master; the controller is the slave.
interface ppwm_if #(
    parameter int NUM_CH      = 2,
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = 7
);
    localparam int CH_W = ppwm_pkg::ch_width(NUM_CH);

    logic                   cfg_valid_i;
    logic                   cfg_ready_o;
    logic [CH_W-1:0]        cfg_ch_i;
    logic [PC_WIDTH-1:0]    cfg_addr_i;
    logic [INSTR_WIDTH-1:0] cfg_data_i;
    logic                   cfg_err_o;
    logic [NUM_CH-1:0]      mem_we_o;
    logic [PC_WIDTH-1:0]    mem_addr_o;
    logic [INSTR_WIDTH-1:0] mem_data_o;

    modport master (
        output cfg_valid_i, cfg_ch_i, cfg_addr_i, cfg_data_i,
        input  cfg_ready_o, cfg_err_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport slave (
        input  cfg_valid_i, cfg_ch_i, cfg_addr_i, cfg_data_i,
        output cfg_ready_o, cfg_err_o, mem_we_o, mem_addr_o, mem_data_o
    );

endinterface

// File: rtl/ppwm_prescaler.sv
// Clock divider for the global counter: one tick every (shadow+1) cycles.
// The shadow only changes on load_i, so a new prescale takes effect at a
// period boundary chosen by the controller.
module ppwm_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    input  logic                      load_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      tick_o
);

    logic [PRESCALE_WIDTH-1:0] div_q;
    logic [PRESCALE_WIDTH-1:0] shadow_q;

    // Tick on the last cycle of each interval; suppressed while held clear.
    assign tick_o = !clr_i && (div_q == shadow_q);

    // Divider: held at 0 while cleared, restarts after every tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (clr_i || tick_o) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Shadow of the prescale input, captured only when the controller asks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (load_i) begin
            shadow_q <= prescale_i;
        end
    end

endmodule

// File: rtl/ppwm_ctrl.sv
// Top-level sequencer for the PWM channels: global counter with period start
// pulse, instruction-memory loading over the config port, channel reset.
// Config writes are only taken while idle, so channels never see their
// program change underneath them.
module ppwm_ctrl
    import ppwm_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int COUNTER_WIDTH  = 8,
    parameter int PRESCALE_WIDTH = 8,
    parameter int INSTR_WIDTH    = 7,
    parameter int PC_WIDTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic [COUNTER_WIDTH-1:0]  top_i,
    ppwm_if.slave                     cfg,
    output logic                      ch_rst_n_o,
    output logic                      start_o,
    output logic [COUNTER_WIDTH-1:0]  global_counter_o,
    output logic                      busy_o
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic is_idle;
    logic tick;
    logic wrap;
    logic go_run;
    logic accept;
    logic ch_ok;
    logic load;

    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] top_sh_q;

    logic                   start_d;
    logic                   run_d;
    logic                   err_d;
    logic [NUM_CH-1:0]      we_d;
    logic [NUM_CH-1:0]      we_q;
    logic                   err_q;
    logic [PC_WIDTH-1:0]    addr_q;
    logic [INSTR_WIDTH-1:0] data_q;

    assign is_idle = (state_q == StIdle);
    assign accept  = cfg.cfg_valid_i && is_idle;
    assign ch_ok   = int'(cfg.cfg_ch_i) < NUM_CH;

    // A pending write beats a run request, so en_i only starts when no write.
    assign go_run  = is_idle && en_i && !cfg.cfg_valid_i;
    assign wrap    = tick && (cnt_q == top_sh_q);

    // Shadows re-latch on entry to run and at each running period boundary.
    assign load    = go_run || ((state_q == StRun) && wrap);

    assign cfg.cfg_ready_o  = is_idle;
    assign cfg.mem_we_o     = we_q;
    assign cfg.cfg_err_o    = err_q;
    assign cfg.mem_addr_o   = addr_q;
    assign cfg.mem_data_o   = data_q;
    assign global_counter_o = cnt_q;

    ppwm_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (is_idle),
        .load_i     (load),
        .prescale_i (prescale_i),
        .tick_o     (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stopping finishes the current period before going idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (go_run) state_d = StRun;
            StRun:  if (!en_i) state_d = StStop;
            StStop: begin
                if (wrap) begin
                    state_d = StIdle;
                end else if (en_i) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: next values of the registered outputs.
    always_comb begin
        start_d = go_run || ((state_q == StRun) && wrap);
        run_d   = (state_d != StIdle);
        err_d   = accept && !ch_ok;
        we_d    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            we_d[c] = accept && (int'(cfg.cfg_ch_i) == c);
        end
    end

    // Registered sequencer outputs; channels leave reset with the first start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_o    <= 1'b0;
            ch_rst_n_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            start_o    <= start_d;
            ch_rst_n_o <= run_d;
            busy_o     <= run_d;
        end
    end

    // Global counter: 0 in idle, advances per tick, wraps after top_sh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (is_idle) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= (cnt_q == top_sh_q) ? '0 : cnt_q + 1'b1;
        end
    end

    // Period length shadow, so top_i edits land on a period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_sh_q <= '0;
        end else if (load) begin
            top_sh_q <= top_i;
        end
    end

    // Config write path: one-cycle strobe, address/data held until next write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= '0;
            err_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q  <= we_d;
            err_q <= err_d;
            if (accept) begin
                addr_q <= cfg.cfg_addr_i;
                data_q <= cfg.cfg_data_i;
            end
        end
    end

endmodule

// File: tb/tb_ppwm_ctrl.sv
// Bench for ppwm_ctrl: directed scenarios then random traffic, checked every
// cycle against a period-position model. A second 3-channel instance stays
// idle and covers the out-of-range channel error path.
module tb_ppwm_ctrl;

    localparam int CW = 8;
    localparam int PW = 8;
    localparam int IW = 7;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic [PW-1:0] ps = '0;
    logic [CW-1:0] top = '0;

    logic          ch_rst_n, start, busy;
    logic [CW-1:0] gcnt;
    logic          ch_rst_n3, start3, busy3;
    logic [CW-1:0] gcnt3;

    ppwm_if #(.NUM_CH(2), .PC_WIDTH(AW), .INSTR_WIDTH(IW)) cif ();
    ppwm_if #(.NUM_CH(3), .PC_WIDTH(AW), .INSTR_WIDTH(IW)) cif3 ();

    ppwm_ctrl #(
        .NUM_CH(2), .COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW),
        .INSTR_WIDTH(IW), .PC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .prescale_i(ps), .top_i(top),
        .cfg(cif), .ch_rst_n_o(ch_rst_n), .start_o(start),
        .global_counter_o(gcnt), .busy_o(busy)
    );

    ppwm_ctrl #(
        .NUM_CH(3), .COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW),
        .INSTR_WIDTH(IW), .PC_WIDTH(AW)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .en_i(1'b0), .prescale_i(ps), .top_i(top),
        .cfg(cif3), .ch_rst_n_o(ch_rst_n3), .start_o(start3),
        .global_counter_o(gcnt3), .busy_o(busy3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a running channel group sits at position m_pos within a period
    // of (top+1)*(ps+1) cycles; the counter is m_pos/(ps+1).
    bit m_active, m_stopping, m_start;
    int m_pos, m_top, m_ps;
    int m_we, m_err, m_addr, m_data;
    int m3_we, m3_err, m3_addr, m3_data;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_cnt();
        return m_active ? m_pos / (m_ps + 1) : 0;
    endfunction

    task automatic model_reset();
        m_active = 0; m_stopping = 0; m_start = 0;
        m_pos = 0; m_top = 0; m_ps = 0;
        m_we = 0; m_err = 0; m_addr = 0; m_data = 0;
        m3_we = 0; m3_err = 0; m3_addr = 0; m3_data = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        int len;
        m_start = 0; m_we = 0; m_err = 0;
        if (!m_active) begin
            if (cif.cfg_valid_i) begin
                if (int'(cif.cfg_ch_i) < 2) m_we = 1 << int'(cif.cfg_ch_i);
                else m_err = 1;
                m_addr = int'(cif.cfg_addr_i);
                m_data = int'(cif.cfg_data_i);
            end else if (en) begin
                m_active = 1; m_stopping = 0; m_pos = 0;
                m_top = int'(top); m_ps = int'(ps); m_start = 1;
            end
        end else begin
            len = (m_top + 1) * (m_ps + 1);
            if (m_pos == len - 1) begin
                m_pos = 0;
                if (m_stopping) begin
                    m_active = 0;
                end else begin
                    m_top = int'(top); m_ps = int'(ps); m_start = 1;
                    m_stopping = !en;
                end
            end else begin
                m_pos++;
                m_stopping = !en;
            end
        end
        m3_we = 0; m3_err = 0;
        if (cif3.cfg_valid_i) begin
            if (int'(cif3.cfg_ch_i) < 3) m3_we = 1 << int'(cif3.cfg_ch_i);
            else m3_err = 1;
            m3_addr = int'(cif3.cfg_addr_i);
            m3_data = int'(cif3.cfg_data_i);
        end
    endtask

    task automatic check_all();
        chk("counter",  32'(gcnt), m_cnt());
        chk("start",    32'(start), 32'(m_start));
        chk("ch_rst_n", 32'(ch_rst_n), 32'(m_active));
        chk("busy",     32'(busy), 32'(m_active));
        chk("ready",    32'(cif.cfg_ready_o), 32'(!m_active));
        chk("mem_we",   32'(cif.mem_we_o), m_we);
        chk("cfg_err",  32'(cif.cfg_err_o), m_err);
        chk("mem_addr", 32'(cif.mem_addr_o), m_addr);
        chk("mem_data", 32'(cif.mem_data_o), m_data);
        chk("ready3",   32'(cif3.cfg_ready_o), 32'(1));
        chk("mem_we3",  32'(cif3.mem_we_o), m3_we);
        chk("cfg_err3", 32'(cif3.cfg_err_o), m3_err);
        chk("mem_addr3", 32'(cif3.mem_addr_o), m3_addr);
        chk("mem_data3", 32'(cif3.mem_data_o), m3_data);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset mid-cycle; released on the following falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (m_cnt() != target && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) chk("wait_cnt", 32'(gcnt), target);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 400) begin
            cycle();
            n++;
        end
        if (n >= 400) chk("wait_idle", 32'(busy), 32'(0));
    endtask

    task automatic set_cfg(input bit v, input int ch, input int a, input int d);
        cif.cfg_valid_i = v;
        cif.cfg_ch_i    = 1'(ch);
        cif.cfg_addr_i  = 4'(a);
        cif.cfg_data_i  = 7'(d);
    endtask

    task automatic set_cfg3(input bit v, input int ch, input int a, input int d);
        cif3.cfg_valid_i = v;
        cif3.cfg_ch_i    = 2'(ch);
        cif3.cfg_addr_i  = 4'(a);
        cif3.cfg_data_i  = 7'(d);
    endtask

    initial begin
        set_cfg(0, 0, 0, 0);
        set_cfg3(0, 0, 0, 0);
        model_reset();
        #1 rst_n = 1'b0;
        #11 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // Config writes: valid channel, then out-of-range on the 3-ch instance.
        set_cfg(1, 1, 5, 'h2A);
        set_cfg3(1, 3, 9, 'h11);
        cycle();
        set_cfg(0, 0, 0, 0);
        set_cfg3(1, 2, 7, 'h55);
        cycle();
        set_cfg3(0, 0, 0, 0);
        cycle();

        // Free run with prescale 0, top 3.
        ps = 8'd0; top = 8'd3; en = 1'b1;
        cycles(12);

        // Prescale 2, top 1; top edited mid-period.
        en = 1'b0; wait_idle();
        ps = 8'd2; top = 8'd1; en = 1'b1;
        cycles(9);
        top = 8'd4;
        cycles(30);

        // Stop at counter 1 runs out the period; then a stop that is cancelled.
        en = 1'b0; wait_idle();
        ps = 8'd0; top = 8'd3; en = 1'b1;
        wait_cnt(1);
        en = 1'b0;
        cycles(5);
        en = 1'b1;
        wait_cnt(1);
        en = 1'b0;
        cycle();
        en = 1'b1;
        cycles(8);

        // top=0: every tick is a wrap.
        en = 1'b0; wait_idle();
        ps = 8'd1; top = 8'd0; en = 1'b1;
        cycles(8);

        // Async reset at counter 2, then write and run requested together.
        ps = 8'd0; top = 8'd3;
        en = 1'b0; wait_idle(); en = 1'b1;
        wait_cnt(2);
        set_cfg(1, 0, 3, 'h11);
        do_reset();
        cycle();
        set_cfg(0, 0, 0, 0);
        cycles(4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0) ps = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) top = 8'($urandom_range(0, 6));
            set_cfg($urandom_range(0, 5) == 0, $urandom_range(0, 1),
                    $urandom_range(0, 15), $urandom_range(0, 127));
            set_cfg3($urandom_range(0, 3) == 0, $urandom_range(0, 3),
                     $urandom_range(0, 15), $urandom_range(0, 127));
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
